// File: rtl/perf_counter_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : perf_pkg
//  Brief    : Shared types and helpers for the performance counter unit.
//  Revision : 1.0  initial release
// ============================================================================
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Read index that selects the cycle counter; events follow at 1..N.
    localparam int RD_SEL_CYCLE = 0;

    function automatic int rd_sel_w(input int num_events);
        return (num_events < 1) ? 1 : $clog2(num_events + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/perf_counter_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : perf_counter_unit_if
//  Brief    : Control, event and readout bundle of the performance counter.
//  Revision : 1.0  initial release
// ============================================================================
interface perf_counter_unit_if #(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_W      = 32
);
    localparam int SEL_W = perf_pkg::rd_sel_w(NUM_EVENTS);

    logic                  start_i;
    logic [NUM_EVENTS-1:0] event_i;
    logic [NUM_EVENTS-1:0] event_en_i;
    logic                  clear_i;
    logic                  snap_i;
    logic [SEL_W-1:0]      rd_sel_i;
    logic [CNT_W-1:0]      rd_data_o;
    logic [CNT_W-1:0]      cycle_o;
    logic [NUM_EVENTS:0]   ovf_o;
    logic                  running_o;
    logic                  done_o;

    modport master (
        output start_i, event_i, event_en_i, clear_i, snap_i, rd_sel_i,
        input  rd_data_o, cycle_o, ovf_o, running_o, done_o
    );

    modport slave (
        input  start_i, event_i, event_en_i, clear_i, snap_i, rd_sel_i,
        output rd_data_o, cycle_o, ovf_o, running_o, done_o
    );

endinterface
`default_nettype wire

// File: rtl/perf_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : perf_sat_counter
//  Brief    : Saturating up-counter with sticky overflow and sync clear.
//  Revision : 1.0  initial release
// ============================================================================
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    // Clear wins over increment; an increment at full scale only flags overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/perf_counter_unit.sv
`default_nettype none
// ============================================================================
//  Module   : perf_counter_unit
//  Brief    : Run-cycle and event performance counters with budgeted stop,
//             snapshot shadow bank and registered readout.
//  Revision : 1.0  initial release
// ============================================================================
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    perf_counter_unit_if.slave  bus
);

    localparam int NUM_CNT = NUM_EVENTS + 1;
    localparam int SEL_W   = rd_sel_w(NUM_EVENTS);
    localparam logic [CNT_W-1:0] LAST_CYCLE =
        (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    logic             running;
    logic [NUM_CNT-1:0] inc_w;
    logic [NUM_CNT-1:0] ovf_w;
    logic [CNT_W-1:0] cnt_w    [NUM_CNT];
    logic [CNT_W-1:0] shadow_q [NUM_CNT];
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_data_d;
    logic             budget_hit;

    // The counter becomes MAX_CYCLES on this edge, unless a clear zeroes it.
    assign budget_hit = (MAX_CYCLES != 0) && !bus.clear_i
                        && (cnt_w[RD_SEL_CYCLE] == LAST_CYCLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (budget_hit) begin
                    state_d = ST_DONE;
                end else if (!bus.start_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (bus.clear_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign running = (state_q == ST_RUN);

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            if (gi == RD_SEL_CYCLE) begin : g_cycle
                assign inc_w[gi] = running;
            end else begin : g_event
                assign inc_w[gi] = running & bus.event_i[gi-1] & bus.event_en_i[gi-1];
            end

            perf_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .clr_i (bus.clear_i),
                .inc_i (inc_w[gi]),
                .cnt_o (cnt_w[gi]),
                .ovf_o (ovf_w[gi])
            );
        end
    endgenerate

    // Shadow captures pre-edge live values, so a simultaneous clear is not seen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (bus.snap_i) begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    shadow_q[i] <= cnt_w[i];
                end
            end
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (bus.rd_sel_i == SEL_W'(i)) begin
                rd_data_d = shadow_q[i];
            end
        end
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.cycle_o   = cnt_w[RD_SEL_CYCLE];
    assign bus.ovf_o     = ovf_w;
    assign bus.running_o = running;
    assign bus.done_o    = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_perf_counter_unit
//  Brief    : Self-checking bench for perf_counter_unit (main and 4-bit build).
//  Revision : 1.0  initial release
// ============================================================================
module tb_perf_counter_unit;
    import perf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    perf_counter_unit_if #(.NUM_EVENTS(4), .CNT_W(32)) if_m ();
    perf_counter_unit_if #(.NUM_EVENTS(2), .CNT_W(4))  if_s ();

    perf_counter_unit #(
        .NUM_EVENTS (4),
        .CNT_W      (32),
        .MAX_CYCLES (64)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_m)
    );

    perf_counter_unit #(
        .NUM_EVENTS (2),
        .CNT_W      (4),
        .MAX_CYCLES (0)
    ) u_sat (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_s)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t     tbl [8];
    int          tbl_n;
    logic [31:0] sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sb_check(input string name);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            chk({name, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            chk(name, if_m.rd_data_o, exp);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl_n; i++) begin
            if_m.rd_sel_i = tbl[i].sel;
            sb_q.push_back(tbl[i].exp);
            step();
            sb_check($sformatf("rd_sel=%0d", tbl[i].sel));
        end
    endtask

    task automatic clear_main();
        if_m.clear_i = 1'b1;
        step();
        if_m.clear_i = 1'b0;
    endtask

    task automatic snap_main();
        if_m.snap_i = 1'b1;
        step();
        if_m.snap_i = 1'b0;
    endtask

    // 20 RUN cycles: ev0 every cycle, ev1 every 4th, ev3 always (masked off).
    task automatic run_events(input logic [3:0] mask);
        if_m.event_en_i = mask;
        clear_main();
        if_m.start_i = 1'b1;
        step();
        for (int c = 0; c < 20; c++) begin
            if_m.event_i = 4'b1001 | (((c % 4) == 0) ? 4'b0010 : 4'b0000);
            if_m.start_i = (c != 19);
            step();
        end
        if_m.event_i = '0;
        chk("events cycle_o", if_m.cycle_o, 32'd20);
        chk("events running_o", {31'd0, if_m.running_o}, 32'd0);
        snap_main();
    endtask

    initial begin
        if_m.start_i = 1'b0; if_m.event_i = '0; if_m.event_en_i = '0;
        if_m.clear_i = 1'b0; if_m.snap_i = 1'b0; if_m.rd_sel_i = '0;
        if_s.start_i = 1'b0; if_s.event_i = '0; if_s.event_en_i = '0;
        if_s.clear_i = 1'b0; if_s.snap_i = 1'b0; if_s.rd_sel_i = '0;

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset cycle_o",   if_m.cycle_o, 32'd0);
        chk("reset ovf_o",     {27'd0, if_m.ovf_o}, 32'd0);
        chk("reset running_o", {31'd0, if_m.running_o}, 32'd0);
        chk("reset done_o",    {31'd0, if_m.done_o}, 32'd0);
        chk("reset rd_data_o", if_m.rd_data_o, 32'd0);

        // Event counting with ev1 enabled, then disabled.
        run_events(4'b0111);
        tbl[0] = '{3'd0, 32'd20}; tbl[1] = '{3'd1, 32'd20}; tbl[2] = '{3'd2, 32'd5};
        tbl[3] = '{3'd3, 32'd0};  tbl[4] = '{3'd4, 32'd0};  tbl[5] = '{3'd5, 32'd0};
        tbl[6] = '{3'd7, 32'd0};  tbl_n = 7;
        run_table();
        chk("events ovf_o", {27'd0, if_m.ovf_o}, 32'd0);

        run_events(4'b0101);
        tbl[0] = '{3'd0, 32'd20}; tbl[1] = '{3'd1, 32'd20}; tbl[2] = '{3'd2, 32'd0};
        tbl[3] = '{3'd3, 32'd0};  tbl[4] = '{3'd4, 32'd0};  tbl_n = 5;
        run_table();

        // Start gap: 10 RUN edges, 5-cycle gap with ev2 strobes while idle, 10 more.
        if_m.event_en_i = 4'b1111;
        clear_main();
        if_m.start_i = 1'b1;
        if_m.event_i = 4'b0001;
        repeat (10) step();
        if_m.start_i = 1'b0;
        if_m.event_i = 4'b0000;
        for (int g = 0; g < 5; g++) begin
            if_m.event_i = (g >= 1 && g <= 3) ? 4'b0100 : 4'b0000;
            step();
        end
        if_m.start_i = 1'b1;
        if_m.event_i = 4'b0001;
        repeat (10) step();
        if_m.start_i = 1'b0;
        if_m.event_i = 4'b0000;
        step();
        chk("gap cycle_o", if_m.cycle_o, 32'd20);
        snap_main();
        tbl[0] = '{3'd0, 32'd20}; tbl[1] = '{3'd1, 32'd18}; tbl[2] = '{3'd3, 32'd0};
        tbl_n = 3;
        run_table();

        // Snapshot together with clear at cycle 7.
        clear_main();
        if_m.start_i = 1'b1;
        step();
        repeat (7) step();
        chk("pre-snap cycle_o", if_m.cycle_o, 32'd7);
        if_m.snap_i   = 1'b1;
        if_m.clear_i  = 1'b1;
        if_m.rd_sel_i = 3'd0;
        sb_q.push_back(32'd7);
        step();
        if_m.snap_i  = 1'b0;
        if_m.clear_i = 1'b0;
        chk("snap+clear cycle_o",   if_m.cycle_o, 32'd0);
        chk("snap+clear running_o", {31'd0, if_m.running_o}, 32'd1);
        step();
        sb_check("snap+clear shadow[0]");
        chk("restart cycle_o", if_m.cycle_o, 32'd1);

        // Asynchronous reset between edges while running.
        #2;
        rst = 1'b1;
        #1;
        chk("async rst cycle_o",   if_m.cycle_o, 32'd0);
        chk("async rst running_o", {31'd0, if_m.running_o}, 32'd0);
        chk("async rst done_o",    {31'd0, if_m.done_o}, 32'd0);
        chk("async rst rd_data_o", if_m.rd_data_o, 32'd0);
        chk("async rst ovf_o",     {27'd0, if_m.ovf_o}, 32'd0);
        if_m.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tbl[0] = '{3'd0, 32'd0}; tbl[1] = '{3'd2, 32'd0}; tbl_n = 2;
        run_table();

        // Cycle budget of 64.
        if_m.start_i = 1'b1;
        step();
        repeat (63) step();
        chk("budget-1 cycle_o", if_m.cycle_o, 32'd63);
        chk("budget-1 done_o",  {31'd0, if_m.done_o}, 32'd0);
        step();
        chk("budget cycle_o",    if_m.cycle_o, 32'd64);
        chk("budget done_o",     {31'd0, if_m.done_o}, 32'd1);
        chk("budget running_o",  {31'd0, if_m.running_o}, 32'd0);
        repeat (3) step();
        chk("done hold cycle_o", if_m.cycle_o, 32'd64);
        chk("done hold done_o",  {31'd0, if_m.done_o}, 32'd1);
        if_m.start_i = 1'b0;
        clear_main();
        chk("done clear cycle_o", if_m.cycle_o, 32'd0);
        chk("done clear done_o",  {31'd0, if_m.done_o}, 32'd0);

        // 4-bit counters, unlimited budget: saturation and sticky overflow.
        if_s.event_en_i = 2'b11;
        if_s.start_i    = 1'b1;
        step();
        if_s.event_i = 2'b01;
        repeat (20) step();
        chk("sat cycle_o",   {28'd0, if_s.cycle_o}, 32'd15);
        chk("sat ovf_o",     {29'd0, if_s.ovf_o}, 32'd3);
        chk("sat done_o",    {31'd0, if_s.done_o}, 32'd0);
        chk("sat running_o", {31'd0, if_s.running_o}, 32'd1);
        if_s.snap_i = 1'b1;
        step();
        if_s.snap_i  = 1'b0;
        if_s.start_i = 1'b0;
        if_s.event_i = 2'b00;
        if_s.clear_i = 1'b1;
        step();
        if_s.clear_i = 1'b0;
        chk("sat clear cycle_o", {28'd0, if_s.cycle_o}, 32'd0);
        chk("sat clear ovf_o",   {29'd0, if_s.ovf_o}, 32'd0);
        chk("sat clear running", {31'd0, if_s.running_o}, 32'd0);
        if_s.rd_sel_i = 2'd1;
        step();
        chk("sat shadow[1]", {28'd0, if_s.rd_data_o}, 32'd15);
        if_s.rd_sel_i = 2'd3;
        step();
        chk("sat shadow oob", {28'd0, if_s.rd_data_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
